// File: rtl/ex_hazard_ctrl.sv
// ex_hazard_ctrl: forwarding selects, stall/flush sequencing and stall
// counter for pre-execute; `EX_HAZARD_MULDIV_EN adds the mul/div wait path.
module ex_hazard_ctrl #(
  parameter int REG_BITS = 5,
  parameter int CNT_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clkEn,
  input  logic                idValid,
  input  logic                idUsesRs1,
  input  logic                idUsesRs2,
  input  logic                idIsMulti,
  input  logic [REG_BITS-1:0] idRs1,
  input  logic [REG_BITS-1:0] idRs2,
  input  logic                exValid,
  input  logic                exWrites,
  input  logic                exIsLoad,
  input  logic [REG_BITS-1:0] exRd,
  input  logic                memValid,
  input  logic                memWrites,
  input  logic [REG_BITS-1:0] memRd,
  input  logic                wbValid,
  input  logic                wbWrites,
  input  logic [REG_BITS-1:0] wbRd,
  input  logic                redirect,
  input  logic                mdDone,
  output logic [1:0]          fwdSel1,
  output logic [1:0]          fwdSel2,
  output logic [2:0]          stall,
  output logic [2:0]          flush,
  output logic                mdStart,
  output logic                mdAbort,
  output logic [1:0]          state,
  output logic [CNT_W-1:0]    stallCount
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MD_WAIT  = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  state_t st_q, st_d;
  logic [CNT_W-1:0] cnt_q;
  logic md_req, md_start, md_abort;
  logic ex1, mem1, wb1, ex2, mem2, wb2;
  logic load_use;

  assign ex1  = exValid & exWrites & (exRd == idRs1)
              & (idRs1 != '0) & idUsesRs1;
  assign mem1 = memValid & memWrites & (memRd == idRs1)
              & (idRs1 != '0) & idUsesRs1;
  assign wb1  = wbValid & wbWrites & (wbRd == idRs1)
              & (idRs1 != '0) & idUsesRs1;
  assign ex2  = exValid & exWrites & (exRd == idRs2)
              & (idRs2 != '0) & idUsesRs2;
  assign mem2 = memValid & memWrites & (memRd == idRs2)
              & (idRs2 != '0) & idUsesRs2;
  assign wb2  = wbValid & wbWrites & (wbRd == idRs2)
              & (idRs2 != '0) & idUsesRs2;

  function automatic logic [1:0] fsel(input logic e,
                                      input logic m,
                                      input logic w);
    if (e)      return 2'd1;
    else if (m) return 2'd2;
    else if (w) return 2'd3;
    else        return 2'd0;
  endfunction

  assign fwdSel1  = fsel(ex1, mem1, wb1);
  assign fwdSel2  = fsel(ex2, mem2, wb2);
  assign load_use = idValid & exIsLoad & (ex1 | ex2);

`ifdef EX_HAZARD_MULDIV_EN
  assign md_req  = idValid & idIsMulti;
  assign mdStart = md_start & clkEn;
  assign mdAbort = md_abort & clkEn;
`else
  logic unused_md;
  assign unused_md = idIsMulti ^ mdDone ^ md_start ^ md_abort;
  assign md_req  = 1'b0;
  assign mdStart = 1'b0;
  assign mdAbort = 1'b0;
`endif

  always_comb begin
    st_d     = st_q;
    stall    = 3'b000;
    flush    = 3'b000;
    md_start = 1'b0;
    md_abort = 1'b0;
    unique case (st_q)
      RUN: begin
        if (redirect) begin
          flush = 3'b110;
          st_d  = REDIRECT;
        end else if (load_use) begin
          stall = 3'b110;
          flush = 3'b001;
        end else if (md_req) begin
          md_start = 1'b1;
          stall    = 3'b110;
          flush    = 3'b001;
          st_d     = MD_WAIT;
        end
      end
`ifdef EX_HAZARD_MULDIV_EN
      MD_WAIT: begin
        if (redirect) begin
          md_abort = 1'b1;
          flush    = 3'b110;
          st_d     = REDIRECT;
        end else if (mdDone) begin
          st_d = RUN;
        end else begin
          stall = 3'b110;
          flush = 3'b001;
        end
      end
`endif
      REDIRECT: begin
        if (redirect) begin
          flush = 3'b110;
        end else begin
          flush = 3'b100;
          st_d  = RUN;
        end
      end
      default: st_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q  <= RUN;
      cnt_q <= '0;
    end else if (clkEn) begin
      st_q <= st_d;
      if (stall[1] && !(&cnt_q))
        cnt_q <= cnt_q + 1'b1;
    end
  end

  assign state      = st_q;
  assign stallCount = cnt_q;

endmodule

// File: doc/ex_hazard_ctrl.md
# ex_hazard_ctrl

Hazard and sequencing controller for the pre-execute stage. Each cycle it compares the ID-stage instruction's source registers against the destinations of instructions in EX, MEM and WB, and drives the 2-bit forwarding selects consumed by the pre-execute stage. It also generates per-stage stall and flush signals for load-use hazards, branch redirects and the multicycle mul/div unit, and keeps a saturating stall-cycle counter for performance monitoring.

## Interface
- `REG_BITS`, 5, architectural register index width
- `CNT_W`, 32, stall counter width
- `clk` in 1: core clock
- `rst` in 1: reset, asynchronous, active-low
- `clkEn` in 1: clock enable; when 0, all registered state holds
- `idValid`, `idUsesRs1`, `idUsesRs2`, `idIsMulti` in 1 each: ID instruction valid, reads rs1, reads rs2, is mul/div
- `idRs1`, `idRs2` in REG_BITS: ID source registers
- `exValid`, `exWrites`, `exIsLoad` in 1 each; `exRd` in REG_BITS: EX-stage producer
- `memValid`, `memWrites` in 1 each; `memRd` in REG_BITS: MEM-stage producer (load data is forwardable from here)
- `wbValid`, `wbWrites` in 1 each; `wbRd` in REG_BITS: WB-stage producer
- `redirect` in 1: branch mispredict from EX
- `mdDone` in 1: mul/div result valid this cycle
- `fwdSel1`, `fwdSel2` out 2: 0 = regfile, 1 = EX, 2 = MEM, 3 = WB
- `stall` out 3: {IF, ID, EX}, hold the stage register
- `flush` out 3: {IF, ID, EX}, EX bit = insert bubble into EX
- `mdStart`, `mdAbort` out 1 each: single-cycle pulses to the mul/div unit
- `state` out 2: FSM state (debug)
- `stallCount` out CNT_W: cycles with stall[ID]=1

## Operation
- Match on port n: producer valid && writes && rd == rsn && rsn != 0 && idUsesRsn.
- Forward priority: EX > MEM > WB > regfile. Register x0 never forwards, so its select is 0.
- Load-use hazard: idValid && an EX match on either port with exIsLoad=1.
- FSM states: RUN=0, MD_WAIT=1, REDIRECT=2. Encoding 3 is illegal and recovers to RUN.
- RUN, evaluated in priority order:
  - redirect: flush={1,1,0}. Next state REDIRECT.
  - load-use: stall={1,1,0}, flush={0,0,1}. Stay in RUN.
  - idValid && idIsMulti: mdStart=1, stall={1,1,0}, flush={0,0,1}. Next state MD_WAIT.
  - otherwise: stall=0, flush=0.
- MD_WAIT:
  - redirect: mdAbort=1, flush={1,1,0}, stall=0. Next state REDIRECT.
  - mdDone: stall=0, flush=0, so the mul/div instruction advances. Next state RUN.
  - otherwise: stall={1,1,0}, flush={0,0,1}.
- REDIRECT: flush={1,0,0}, stall=0, hazards ignored. Next state RUN. A new redirect in this state flushes {1,1,0} and stays in REDIRECT.
- fwdSel is computed combinationally in every state.
- stallCount increments when clkEn && stall[1], and saturates at all-ones.

## Timing
- fwdSel, stall, flush, mdStart and mdAbort are combinational from the inputs and the current state, with 0-cycle latency.
- FSM and stallCount update on the rising edge of clk, only when clkEn=1.
- clkEn=0 forces mdStart and mdAbort to 0. stall and flush are still driven.
- mdStart occurs at most once per mul/div instruction. mdDone has no effect outside MD_WAIT.
- While reset is asserted: state=RUN, stallCount=0. With all valids low, every output is 0.
- Reset asserted mid-MD_WAIT returns the FSM to RUN immediately. No mdAbort is issued; the mul/div unit shares the same reset.

## Configuration
- `EX_HAZARD_MULDIV_EN` defined: the MD_WAIT path, mdStart and mdAbort are present as described above.
- `EX_HAZARD_MULDIV_EN` undefined:
  - idIsMulti and mdDone are ignored.
  - MD_WAIT is unreachable.
  - mdStart and mdAbort are tied to 0.
  - A mul/div instruction issues like an ALU operation.

## Test plan
- Forwarding: ID rs1=5, rs2=5 with EX writing x5 and MEM writing x5 -> fwdSel1=fwdSel2=1. Drop EX valid -> 2. Then only WB writing x5 -> 3. Same test with rs=0 -> select stays 0.
- Load-use: EX load to x7, ID uses rs2=7 -> stall=3'b110, flush=3'b001 for one cycle. Next cycle, load in MEM -> fwdSel2=2, stall=0, stallCount=1.
- Mul/div: idIsMulti in RUN -> mdStart pulse, state=1. Four stall cycles, then mdDone -> stall=0 that cycle, state=0 next cycle, stallCount=5, exactly one mdStart seen.
- Redirect during MD_WAIT -> mdAbort=1, flush=3'b110. Next cycle state=2, flush=3'b100. Then state=0.
- clkEn=0 in MD_WAIT with mdDone=1 -> state stays 1 and stallCount is frozen. Reset asserted asynchronously mid-wait -> state=0, stallCount=0 without waiting for a clock edge.
- Build without the macro: idIsMulti=1 -> no stall, mdStart=0, state stays 0.
